// File: rtl/sha3_share_pkg.sv
// sha3_share_pkg: shared widths and FSM state encoding for the SHA3 core-sharing controller
package sha3_share_pkg;

    localparam int DEF_WORD_W   = 64;
    localparam int DEF_DIGEST_W = 512;
    localparam int BYTE_NUM_W   = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_STREAM  = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_DELIVER = 3'd3;
    localparam state_t ST_CLEAR   = 3'd4;

endpackage

// File: rtl/sha3_share_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin picker with a registered last-owner pointer
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic last_q;

    // On a tie the requester that did not own the core last time wins
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = req_i[1] & (~req_i[0] | ~last_q);
    end

    // Remember each winner; starting at 1 lets requester 0 win the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_q <= 1'b1;
        else if (grant_en_i && gnt_valid_o) last_q <= gnt_id_o;
    end

endmodule

// File: rtl/sha3_share_ctrl.sv
// sha3_share_ctrl: shares one SHA3 core between two requesters; SHA3_SHARE_CTRL_WATCHDOG_EN adds a digest watchdog
module sha3_share_ctrl
    import sha3_share_pkg::*;
#(
    parameter int WORD_W       = DEF_WORD_W,
    parameter int DIGEST_W     = DEF_DIGEST_W,
    parameter int CLEAR_CYCLES = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              req_valid,
    input  logic [2*WORD_W-1:0]     req_data,
    input  logic [1:0]              req_last,
    input  logic [2*BYTE_NUM_W-1:0] req_byte_num,
    output logic [1:0]              req_ready,
    output logic [1:0]              resp_valid,
    input  logic [1:0]              resp_ack,
    output logic                    resp_err,
    output logic [DIGEST_W-1:0]     digest,
    output logic                    busy,
    output logic                    grant_id,
    output logic [WORD_W-1:0]       sha3_in,
    output logic                    sha3_in_ready,
    output logic                    sha3_is_last,
    output logic [BYTE_NUM_W-1:0]   sha3_byte_num,
    output logic                    sha3_reset,
    input  logic                    sha3_buffer_full,
    input  logic [DIGEST_W-1:0]     sha3_out,
    input  logic                    sha3_out_ready
);

    if (CLEAR_CYCLES < 1 || CLEAR_CYCLES > 15 || TIMEOUT < 1) begin : g_bad_cfg
        $error("sha3_share_ctrl: CLEAR_CYCLES must be 1..15 and TIMEOUT at least 1");
    end

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic [3:0]          clr_q, clr_d;
    logic                arb_valid, arb_id, stream, xfer;

`ifdef SHA3_SHARE_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign grant_id = grant_q;
    assign digest   = digest_q;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_i      (req_valid),
        .grant_en_i (state_q == ST_IDLE),
        .gnt_valid_o(arb_valid),
        .gnt_id_o   (arb_id)
    );

    // Owner's word passes straight to the core; ready follows buffer_full in the same cycle
    always_comb begin
        stream        = state_q == ST_STREAM;
        req_ready     = {stream && grant_q && !sha3_buffer_full, stream && !grant_q && !sha3_buffer_full};
        xfer          = req_valid[grant_q] && req_ready[grant_q];
        sha3_in       = grant_q ? req_data[2*WORD_W-1:WORD_W] : req_data[WORD_W-1:0];
        sha3_in_ready = xfer;
        sha3_is_last  = stream && req_last[grant_q];
        sha3_byte_num = !stream ? '0 : grant_q ? req_byte_num[2*BYTE_NUM_W-1:BYTE_NUM_W] : req_byte_num[BYTE_NUM_W-1:0];
        resp_valid    = {2{state_q == ST_DELIVER}} & {grant_q, !grant_q};
        busy          = state_q != ST_IDLE;
        sha3_reset    = !reset_n || state_q == ST_CLEAR;
    end

    // Message sequencing: grant, stream, capture, deliver, then clear the core
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        digest_d = digest_q;
        clr_d    = clr_q;
`ifdef SHA3_SHARE_CTRL_WATCHDOG_EN
        wd_d     = wd_q;
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: if (arb_valid) begin
                state_d = ST_STREAM;
                grant_d = arb_id;
            end
            ST_STREAM: if (xfer && req_last[grant_q]) begin
                state_d = ST_WAIT;
`ifdef SHA3_SHARE_CTRL_WATCHDOG_EN
                wd_d    = WD_W'(TIMEOUT - 1);
`endif
            end
            ST_WAIT: if (sha3_out_ready) begin
                state_d  = ST_DELIVER;
                digest_d = sha3_out;
            end
`ifdef SHA3_SHARE_CTRL_WATCHDOG_EN
            else if (wd_q == '0) begin
                state_d  = ST_DELIVER;
                digest_d = '0;
                err_d    = 1'b1;
            end
            else wd_d = wd_q - WD_W'(1);
`endif
            ST_DELIVER: if (resp_ack[grant_q]) begin
                state_d = ST_CLEAR;
                clr_d   = 4'(CLEAR_CYCLES - 1);
`ifdef SHA3_SHARE_CTRL_WATCHDOG_EN
                err_d   = 1'b0;
`endif
            end
            ST_CLEAR: if (clr_q == '0) state_d = ST_IDLE;
                      else clr_d = clr_q - 4'd1;
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state; reset aborts any message in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b0;
            digest_q <= '0;
            clr_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            digest_q <= digest_d;
            clr_q    <= clr_d;
        end
    end

`ifdef SHA3_SHARE_CTRL_WATCHDOG_EN
    // Watchdog counter and error flag for a core that never produces a digest
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_sha3_share_ctrl.sv
// tb_sha3_share_ctrl: table-driven, scoreboarded bench for sha3_share_ctrl
module tb_sha3_share_ctrl;

    localparam int W  = 64;
    localparam int DW = 512;
    localparam int CC = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [1:0]     req_valid, req_last, req_ready, resp_valid, resp_ack;
    logic [2*W-1:0] req_data;
    logic [5:0]     req_byte_num;
    logic           resp_err, busy, grant_id, sha3_in_ready, sha3_is_last, sha3_reset;
    logic           sha3_buffer_full, sha3_out_ready;
    logic [DW-1:0]  digest, sha3_out;
    logic [W-1:0]   sha3_in;
    logic [2:0]     sha3_byte_num;

    int errs = 0;
    int checks = 0;
    logic [67:0]  word_q[$];
    logic [514:0] resp_q[$];
    logic [1:0]   prev_rv = 2'b00;

    typedef struct {
        logic [1:0]    mask;
        logic          g;
        int            nw;
        logic [2:0]    bn;
        logic [DW-1:0] d;
        bit            stall;
        bit            xack;
    } vec_t;
    vec_t tbl[7];

    sha3_share_ctrl #(.WORD_W(W), .DIGEST_W(DW), .CLEAR_CYCLES(CC), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_byte_num(req_byte_num),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ack(resp_ack), .resp_err(resp_err),
        .digest(digest), .busy(busy), .grant_id(grant_id),
        .sha3_in(sha3_in), .sha3_in_ready(sha3_in_ready), .sha3_is_last(sha3_is_last),
        .sha3_byte_num(sha3_byte_num), .sha3_reset(sha3_reset), .sha3_buffer_full(sha3_buffer_full),
        .sha3_out(sha3_out), .sha3_out_ready(sha3_out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [599:0] act, input logic [599:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errs++;
        $display("FAIL %s: event seen, none required", name);
    endtask

    function automatic logic [W-1:0] word(input int i, input int k);
        return 64'h0123456789ABCDEF + (64'(i) << 32) + 64'(k) * 64'h1111;
    endfunction

    // Scoreboard: pop expected words and responses as the DUT emits them
    task automatic mon();
        logic [67:0]  w;
        logic [514:0] r;
        if (reset_n && sha3_in_ready) begin
            if (word_q.size() == 0) fail("word_unexpected");
            else begin
                w = word_q.pop_front();
                chk("word", {sha3_in, sha3_is_last, sha3_byte_num}, w);
            end
        end
        if (resp_valid != 2'b00 && prev_rv == 2'b00) begin
            if (resp_q.size() == 0) fail("resp_unexpected");
            else begin
                r = resp_q.pop_front();
                chk("resp", {resp_valid, digest, resp_err}, r);
            end
        end
        prev_rv = resp_valid;
    endtask

    task automatic samp();
        @(negedge clk);
        mon();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] mask, input logic g, input int k, input int nw, input logic [2:0] bn);
        req_valid = mask;
        req_data  = g ? {word(1, k), word(0, 0)} : {word(1, 0), word(0, k)};
        req_last  = 2'b00;
        req_last[g] = (k == nw - 1);
        req_byte_num = '0;
        if (k == nw - 1) req_byte_num[int'(g)*3 +: 3] = bn;
    endtask

    task automatic run_round(input logic [1:0] mask, input logic g, input int nw, input logic [2:0] bn,
                             input logic [DW-1:0] d, input bit stall, input bit xack, input bit wd);
        int k, t;
        logic [1:0] gb, ob;
        gb = g ? 2'b10 : 2'b01;
        ob = ~gb;
        for (int i = 0; i < nw; i++)
            word_q.push_back({word(int'(g), i), i == nw - 1, i == nw - 1 ? bn : 3'd0});
        drive(mask, g, 0, nw, bn);
        samp();
        chk("ready_latency", req_ready, 0);
        chk("idle_busy", busy, 0);
        step();
        k = 0;
        t = 0;
        while (k < nw && t < 100) begin
            sha3_buffer_full = stall && t >= 1 && t <= 5;
            drive(mask, g, k, nw, bn);
            samp();
            chk("grant_id", grant_id, g);
            chk("stream_busy", busy, 1);
            chk("req_ready", req_ready, sha3_buffer_full ? 2'b00 : gb);
            chk("in_ready", sha3_in_ready, !sha3_buffer_full);
            step();
            if (!sha3_buffer_full) k++;
            t++;
        end
        if (k < nw) fail("stream_timeout");
        sha3_buffer_full = 1'b0;
        req_valid = 2'b00;
        req_last = 2'b00;
        chk("words_left", word_q.size(), 0);
        sha3_out = ~d;
        samp();
        chk("wait_busy", busy, 1);
        chk("wait_resp", resp_valid, 0);
        step();
        if (wd) begin
            resp_q.push_back({gb, {DW{1'b0}}, 1'b1});
            for (int c = 1; c < 16; c++) begin
                samp();
                chk("wd_early", resp_valid, 0);
                step();
            end
        end else begin
            resp_q.push_back({gb, d, 1'b0});
            sha3_out = d;
            sha3_out_ready = 1'b1;
            samp();
            chk("cap_resp", resp_valid, 0);
            step();
            sha3_out_ready = 1'b0;
            sha3_out = ~d;
        end
        samp();
        chk("resp_valid", resp_valid, gb);
        chk("digest", digest, wd ? {DW{1'b0}} : d);
        chk("resp_err", resp_err, wd);
        chk("resp_left", resp_q.size(), 0);
        step();
        if (xack) begin
            resp_ack = ob;
            samp();
            chk("xack_hold", resp_valid, gb);
            step();
            resp_ack = 2'b00;
            samp();
            chk("xack_ignored", {resp_valid, sha3_reset}, {gb, 1'b0});
            step();
        end
        resp_ack = gb;
        samp();
        chk("ack_cycle", resp_valid, gb);
        step();
        resp_ack = 2'b00;
        for (int c = 0; c < CC; c++) begin
            samp();
            chk("clear_reset", {sha3_reset, resp_valid, resp_err}, 4'b1000);
            chk("digest_hold", digest, wd ? {DW{1'b0}} : d);
            step();
        end
        samp();
        chk("idle_after_clear", {sha3_reset, busy}, 2'b00);
        step();
    endtask

    initial begin
        tbl[0] = '{2'b11, 1'b0, 3, 3'd1, '0, 1'b0, 1'b0};
        tbl[1] = '{2'b11, 1'b1, 2, 3'd7, '0, 1'b0, 1'b0};
        tbl[2] = '{2'b11, 1'b0, 1, 3'd0, '0, 1'b0, 1'b1};
        tbl[3] = '{2'b01, 1'b0, 2, 3'd3, '0, 1'b0, 1'b0};
        tbl[4] = '{2'b10, 1'b1, 4, 3'd2, '0, 1'b1, 1'b0};
        tbl[5] = '{2'b11, 1'b0, 2, 3'd6, '0, 1'b0, 1'b0};
        tbl[6] = '{2'b11, 1'b1, 3, 3'd5, '0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) tbl[i].d = {16{32'hD16E0000 | 32'(i + 1)}};

        reset_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0; req_byte_num = '0; resp_ack = '0;
        sha3_buffer_full = 1'b0; sha3_out = '0; sha3_out_ready = 1'b0;
        samp();
        chk("reset_vals", {req_ready, resp_valid, resp_err, busy, grant_id, sha3_in_ready, sha3_is_last,
                           sha3_byte_num, sha3_reset}, 13'b1);
        chk("reset_digest", digest, 0);
        step();
        reset_n = 1'b1;
        samp();
        chk("reset_release", sha3_reset, 0);
        step();

        for (int i = 0; i < 7; i++)
            run_round(tbl[i].mask, tbl[i].g, tbl[i].nw, tbl[i].bn, tbl[i].d, tbl[i].stall, tbl[i].xack, 1'b0);

        word_q.push_back({word(0, 0), 1'b0, 3'd0});
        drive(2'b01, 1'b0, 0, 3, 3'd0);
        samp();
        step();
        samp();
        chk("rst_pre_ready", req_ready, 2'b01);
        step();
        drive(2'b01, 1'b0, 1, 3, 3'd0);
        reset_n = 1'b0;
        samp();
        chk("midrst_vals", {req_ready, resp_valid, resp_err, busy, grant_id, sha3_in_ready, sha3_is_last,
                            sha3_byte_num, sha3_reset}, 13'b1);
        chk("midrst_digest", digest, 0);
        chk("midrst_words", word_q.size(), 0);
        step();
        req_valid = 2'b00;
        samp();
        step();
        reset_n = 1'b1;
        samp();
        chk("midrst_release", {sha3_reset, busy}, 2'b00);
        step();
        run_round(2'b10, 1'b1, 2, 3'd5, {8{64'hFEEDFACE0BADF00D}}, 1'b0, 1'b0, 1'b0);

`ifdef SHA3_SHARE_CTRL_WATCHDOG_EN
        run_round(2'b01, 1'b0, 2, 3'd4, {DW{1'b1}}, 1'b0, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
